// File: rtl/conv_window_gen_3ch.sv
// Streaming 5x5 sliding-window generator for a 3-channel raster image (valid convolution, no padding).
// Optional build macro CONV_WIN_STRIDE2_EN: emit only every second window in both directions.
module conv_window_gen_3ch #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pix_valid,
    input  logic                      sof,
    input  logic [3*DATA_W-1:0]       pix_in,
    output logic                      win_valid,
    output logic [25*DATA_W-1:0]      ch0_flat,
    output logic [25*DATA_W-1:0]      ch1_flat,
    output logic [25*DATA_W-1:0]      ch2_flat,
    output logic [$clog2(IMG_H)-1:0]  win_row,
    output logic [$clog2(IMG_W)-1:0]  win_col,
    output logic                      frame_done
);

    localparam int PW = 3 * DATA_W;
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_THREE = RW'(3);
    localparam logic [RW-1:0] ROW_FOUR  = RW'(4);
    localparam logic [CW-1:0] COL_FOUR  = CW'(4);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic            accept;
    logic [RW-1:0]   cur_r;
    logic [CW-1:0]   cur_c;
    logic            last_col;
    logic            last_pix;
    logic            emit_p0;
    logic [RW-1:0]   emit_row_p0;
    logic [CW-1:0]   emit_col_p0;

    logic [PW-1:0]   lb      [4][IMG_W];
    logic [PW-1:0]   col_new [5];
    logic [PW-1:0]   win     [5][5];

    // A sof pixel always lands at (0,0), whether it opens a frame or aborts one.
    always_comb begin
        accept   = pix_valid && (state != IDLE || sof);
        cur_r    = sof ? '0 : row;
        cur_c    = sof ? '0 : col;
        last_col = (cur_c == COL_LAST);
        last_pix = last_col && (cur_r == ROW_LAST);
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (sof) begin
                state_nxt = FILL;
            end else begin
                case (state)
                    FILL:    if (cur_r == ROW_THREE && last_col) state_nxt = RUN;
                    RUN:     if (last_pix) state_nxt = IDLE;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            col <= last_col ? '0 : cur_c + 1'b1;
            if (last_col) row <= last_pix ? '0 : cur_r + 1'b1;
            else          row <= cur_r;
        end
    end

    // Row guard also hides stale line-buffer contents left by an aborted frame.
    always_comb begin
        emit_p0     = accept && (cur_r >= ROW_FOUR) && (cur_c >= COL_FOUR);
        emit_row_p0 = cur_r - ROW_FOUR;
        emit_col_p0 = cur_c - COL_FOUR;
`ifdef CONV_WIN_STRIDE2_EN
        emit_p0     = emit_p0 && !cur_r[0] && !cur_c[0];
        emit_row_p0 = emit_row_p0 >> 1;
        emit_col_p0 = emit_col_p0 >> 1;
`endif
    end

    // Stage p0 -> p1: window outputs registered one cycle after the completing pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= emit_p0;
            frame_done <= accept && !sof && (state == RUN) && last_pix;
            if (emit_p0) begin
                win_row <= emit_row_p0;
                win_col <= emit_col_p0;
            end
        end
    end

    // Per-column history: lb[0] is the previous row, lb[3] the oldest.
    always_comb begin
        col_new[0] = lb[3][cur_c];
        col_new[1] = lb[2][cur_c];
        col_new[2] = lb[1][cur_c];
        col_new[3] = lb[0][cur_c];
        col_new[4] = pix_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++)
                for (int x = 0; x < IMG_W; x++)
                    lb[k][x] <= '0;
            for (int ry = 0; ry < 5; ry++)
                for (int cx = 0; cx < 5; cx++)
                    win[ry][cx] <= '0;
        end else if (accept) begin
            lb[0][cur_c] <= pix_in;
            lb[1][cur_c] <= lb[0][cur_c];
            lb[2][cur_c] <= lb[1][cur_c];
            lb[3][cur_c] <= lb[2][cur_c];
            for (int ry = 0; ry < 5; ry++) begin
                for (int cx = 0; cx < 4; cx++)
                    win[ry][cx] <= win[ry][cx+1];
                win[ry][4] <= col_new[ry];
            end
        end
    end

    // Element i = ry*5+cx, element 0 (top-left, oldest) in the MSBs.
    for (genvar i = 0; i < 25; i++) begin : g_flat
        assign ch0_flat[(25-i)*DATA_W-1 -: DATA_W] = win[i/5][i%5][DATA_W-1:0];
        assign ch1_flat[(25-i)*DATA_W-1 -: DATA_W] = win[i/5][i%5][2*DATA_W-1:DATA_W];
        assign ch2_flat[(25-i)*DATA_W-1 -: DATA_W] = win[i/5][i%5][3*DATA_W-1:2*DATA_W];
    end

endmodule

// File: tb/tb_conv_window_gen_3ch.sv
// Scoreboard bench for conv_window_gen_3ch on an 8x8 image; honours CONV_WIN_STRIDE2_EN.
module tb_conv_window_gen_3ch;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 8;
`ifdef CONV_WIN_STRIDE2_EN
    localparam int STR = 2;
`else
    localparam int STR = 1;
`endif
    localparam int WPF      = ((W - 4 + STR - 1) / STR) * ((H - 4 + STR - 1) / STR);
    localparam int ROW4_WIN = (W - 4 + STR - 1) / STR;

    logic              clk;
    logic              rst_n;
    logic              pix_valid;
    logic              sof;
    logic [3*DW-1:0]   pix_in;
    logic              win_valid;
    logic [25*DW-1:0]  ch0_flat;
    logic [25*DW-1:0]  ch1_flat;
    logic [25*DW-1:0]  ch2_flat;
    logic [2:0]        win_row;
    logic [2:0]        win_col;
    logic              frame_done;

    conv_window_gen_3ch #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .sof(sof), .pix_in(pix_in),
        .win_valid(win_valid), .ch0_flat(ch0_flat), .ch1_flat(ch1_flat), .ch2_flat(ch2_flat),
        .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
    );

    typedef struct {
        int               cyc;
        logic [2:0]       row;
        logic [2:0]       col;
        logic [25*DW-1:0] f0;
        logic [25*DW-1:0] f1;
        logic [25*DW-1:0] f2;
    } exp_t;

    exp_t win_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   nwin_total = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] img_ch(input int kind, input int ch, input int r, input int c);
        int v;
        logic [7:0] b;
        v = r * W + c;
        if (kind == 0) begin
            b = 8'(v + 64 * ch);
        end else begin
            b = 8'(255 - v);
            if (ch == 1) b = b ^ 8'hA5;
            if (ch == 2) b = b + 8'd1;
        end
        return b;
    endfunction

    function automatic logic [25*DW-1:0] exp_flat(input int kind, input int ch, input int r0, input int c0);
        logic [25*DW-1:0] f;
        f = '0;
        for (int i = 0; i < 25; i++)
            f[(25-i)*DW-1 -: DW] = img_ch(kind, ch, r0 + i / 5, c0 + i % 5);
        return f;
    endfunction

    // Output side of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (win_valid) begin
                if (win_q.size() == 0) begin
                    chk("win_spurious", 200'(win_valid), 200'(0));
                end else begin
                    e = win_q.pop_front();
                    nwin_total++;
                    chk("win_latency", 200'(cyc), 200'(e.cyc));
                    chk("win_row", 200'(win_row), 200'(e.row));
                    chk("win_col", 200'(win_col), 200'(e.col));
                    chk("ch0_flat", ch0_flat, e.f0);
                    chk("ch1_flat", ch1_flat, e.f1);
                    chk("ch2_flat", ch2_flat, e.f2);
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) chk("done_spurious", 200'(frame_done), 200'(0));
                else                    chk("done_cycle", 200'(cyc), 200'(done_q.pop_front()));
            end
        end
    end

    task automatic send_pixel(input int kind, input int r, input int c, input bit s, input bit tracked);
        exp_t e;
        @(negedge clk);
        pix_valid = 1'b1;
        sof       = s;
        if (kind < 0) pix_in = 24'($urandom);
        else          pix_in = {img_ch(kind, 2, r, c), img_ch(kind, 1, r, c), img_ch(kind, 0, r, c)};
        if (tracked && r >= 4 && c >= 4 && (r - 4) % STR == 0 && (c - 4) % STR == 0) begin
            e.cyc = cyc + 1;
            e.row = 3'((r - 4) / STR);
            e.col = 3'((c - 4) / STR);
            e.f0  = exp_flat(kind, 0, r - 4, c - 4);
            e.f1  = exp_flat(kind, 1, r - 4, c - 4);
            e.f2  = exp_flat(kind, 2, r - 4, c - 4);
            win_q.push_back(e);
        end
        if (tracked && r == H - 1 && c == W - 1) done_q.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sof       = 1'b0;
        end
    endtask

    task automatic send_frame(input int kind, input bit gap, input int stop_r, input int stop_c);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r < stop_r || (r == stop_r && c <= stop_c)) begin
                    send_pixel(kind, r, c, (r == 0 && c == 0), 1'b1);
                    if (gap) idle(1);
                end
    endtask

    task automatic end_phase(input string tag, input int base, input int exp_n);
        idle(4);
        chk({tag, "_nwin"}, 200'(nwin_total - base), 200'(exp_n));
        chk({tag, "_win_q_empty"}, 200'(win_q.size()), 200'(0));
        chk({tag, "_done_q_empty"}, 200'(done_q.size()), 200'(0));
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        pix_in    = '0;
        repeat (3) @(negedge clk);
        chk("rst_win_valid", 200'(win_valid), 200'(0));
        chk("rst_frame_done", 200'(frame_done), 200'(0));
        chk("rst_ch0_flat", ch0_flat, 200'(0));
        chk("rst_ch2_flat", ch2_flat, 200'(0));
        chk("rst_win_row", 200'(win_row), 200'(0));
        chk("rst_win_col", 200'(win_col), 200'(0));
        rst_n = 1'b1;
        idle(2);

        base = nwin_total;
        send_frame(0, 1'b0, H - 1, W - 1);
        end_phase("continuous", base, WPF);

        base = nwin_total;
        send_frame(0, 1'b1, H - 1, W - 1);
        end_phase("gapped", base, WPF);

        base = nwin_total;
        for (int i = 0; i < 5; i++) send_pixel(-1, 0, 0, 1'b0, 1'b0);
        send_frame(0, 1'b0, H - 1, W - 1);
        end_phase("idle_drop", base, WPF);

        base = nwin_total;
        send_frame(0, 1'b0, 5, 1);
        send_frame(1, 1'b0, H - 1, W - 1);
        end_phase("abort", base, WPF + ROW4_WIN);

        send_frame(0, 1'b0, 6, 6);
        @(posedge clk);
        #1;
        chk("pre_rst_win_valid", 200'(win_valid), 200'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_win_valid", 200'(win_valid), 200'(0));
        chk("async_rst_frame_done", 200'(frame_done), 200'(0));
        chk("async_rst_win_row", 200'(win_row), 200'(0));
        pix_valid = 1'b0;
        sof       = 1'b0;
        win_q.delete();
        done_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(2);
        base = nwin_total;
        send_frame(0, 1'b0, H - 1, W - 1);
        end_phase("after_reset", base, WPF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_gen_3ch.md
Name: conv_window_gen_3ch

Overview:
Streaming 5x5 sliding-window generator for a 3-channel image. It sits upstream of the 3-channel 5x5 conv sum PE and feeds that PE's ch0/ch1/ch2 flattened window inputs and its valid_in.
- Accepts one 3-channel pixel per cycle in raster order.
- Buffers 4 previous lines per channel.
- Emits one full 5x5x3 window per valid output position (no padding; "valid" convolution).

Parameters:
DATA_W, 8, bits per channel sample
IMG_W, 32, image width in pixels (>=5)
IMG_H, 32, image height in pixels (>=5)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
pix_valid  input  1  pixel strobe; one pixel accepted per cycle when high
sof  input  1  start of frame; qualified by pix_valid, marks pixel (0,0)
pix_in  input  3*DATA_W  {ch2,ch1,ch0}; ch0 in [DATA_W-1:0]
win_valid  output  1  window outputs valid this cycle (drives PE valid_in)
ch0_flat  output  25*DATA_W  channel-0 window
ch1_flat  output  25*DATA_W  channel-1 window
ch2_flat  output  25*DATA_W  channel-2 window
win_row  output  clog2(IMG_H)  output-grid row of current window
win_col  output  clog2(IMG_W)  output-grid column of current window
frame_done  output  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - win_valid=0, frame_done=0, flats=0, win_row=0, win_col=0.
  - Line buffers and window registers cleared.
  - FSM in IDLE.
- No backpressure: the downstream PE is fully pipelined and always accepts.
- FSM states:
  - IDLE: pix_valid&sof -> accept as (0,0), go to FILL. pix_valid without sof is dropped.
  - FILL: rows 0..3, no windows emitted. Accepting pixel (3,IMG_W-1) -> RUN.
  - RUN: rows 4..IMG_H-1. Accepting pixel (IMG_H-1,IMG_W-1) -> IDLE, with frame_done=1 next cycle.
- Counters col/row advance only on accepted pixels. col wraps at IMG_W-1 to 0 and increments row.
- Storage:
  - 4 line buffers per channel, IMG_W deep, written at col each accepted pixel (line shift on row wrap, or circular row pointer).
  - 5x5 window shift register per channel; each accepted pixel shifts in one new column of 5 samples: 4 from line buffers (oldest row on top) plus pix_in.
- Window emission:
  - Accepting pixel (r,c) with r>=4 and c>=4 gives, on the next cycle: win_valid=1, win_row=r-4, win_col=c-4.
  - Latency is 1 cycle from the completing pixel.
  - Windows whose columns straddle a row wrap are never flagged valid (c>=4 guard).
- Flat ordering: element i=ry*5+cx, where ry=0 is the top (oldest) row and cx=0 is the leftmost (oldest) column. Element i occupies bits [(25-i)*DATA_W-1 -: DATA_W], so element 0 is in the MSBs.
- Flats hold their value when win_valid=0 (no requirement on content).
- Gaps in pix_valid: state holds and no window is emitted; resumes seamlessly.
- sof with pix_valid in FILL/RUN: abort the frame and restart at (0,0) with that pixel (state FILL). No frame_done for the aborted frame. Stale line-buffer data is masked by the row guard.
- frame_done and the last win_valid are asserted in the same cycle.
- Reset mid-frame: immediate return to reset values; the next frame requires sof.
- Windows per frame: (IMG_W-4)*(IMG_H-4).

Optional Feature:
CONV_WIN_STRIDE2_EN
- Defined: windows are emitted only where (r-4) and (c-4) are both even. win_row=(r-4)/2 and win_col=(c-4)/2. Windows per frame: ceil((IMG_W-4)/2)*ceil((IMG_H-4)/2).
- Undefined: stride 1 as above.

Test Plan:
1. IMG_W=IMG_H=8. Stream one frame with ch0=r*8+c, ch1=ch0+64, ch2=ch0+128, pix_valid continuous -> exactly 16 win_valid pulses. First pulse 1 cycle after pixel (4,4): ch0 element0=0, element24=36; ch1 element0=64; win_row=0, win_col=0. frame_done pulses together with the 16th window (ch0 element24=63).
2. Same frame with pix_valid toggling every other cycle -> identical 16 windows and contents, each emitted 1 cycle after its completing pixel.
3. Pixels without sof while IDLE, then a valid frame -> the leading pixels are ignored; window contents match test 1.
4. Abort: sof reasserted at pixel (5,2) of frame A, then full frame B (ch0=255-(r*8+c)) -> no frame_done for A. B's first window has ch0 element0=255, with no data from A.
5. rst_n asserted mid-RUN -> win_valid and frame_done go to 0 immediately. The following frame reproduces test 1 exactly.
6. With CONV_WIN_STRIDE2_EN, 8x8 frame -> 4 windows at pixel origins (0,0),(0,2),(2,0),(2,2). win_row/win_col = (0,0),(0,1),(1,0),(1,1). Windows at (0,2) origin have ch0 element0=2.
